// File: rtl/i2c_cmd_sequencer_pkg.sv
// Purpose: shared types and defaults for the I2C command sequencer (FSM states, command entry).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_REPORT
    } state_t;

    // One queued command as stored in the FIFO: {rw, addr, data}.
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Purpose: bundles the host command handshake, the I2C master control and the status outputs.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake on the host side; m_busy is the only feedback from the master.
// Modports: slave = the sequencer (receives commands, drives the master), master = the environment
// (host plus I2C master) driving commands and m_busy.
interface i2c_cmd_sequencer_if #(
    parameter int FIFO_DEPTH = i2c_pkg::FIFO_DEPTH_DEF
);
    import i2c_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rw;
    logic [6:0]       cmd_addr;
    logic [7:0]       cmd_data;
    logic             m_start;
    logic             m_rw;
    logic [6:0]       m_addr;
    logic [7:0]       m_data;
    logic             m_busy;
    logic             done;
    logic             timeout_err;
    logic [LVL_W-1:0] fifo_level;
    logic             idle;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_data, m_busy,
        output cmd_ready, m_start, m_rw, m_addr, m_data,
               done, timeout_err, fifo_level, idle
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_data, m_busy,
        input  cmd_ready, m_start, m_rw, m_addr, m_data,
               done, timeout_err, fifo_level, idle
    );

endinterface

// File: rtl/i2c_cmd_sequencer_sync_fifo.sv
// Purpose: generic circular-buffer FIFO with show-ahead read data (o_dout is the current head).
// Latency: a push is visible at o_dout / o_level on the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; o_full tells the producer to hold.
// Ports: clk, rst (sync, active-high); i_push/i_din write side; i_pop read side; o_dout head entry;
// o_full, o_empty, o_level occupancy.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Purpose: queues host I2C commands and issues them one at a time to an I2C master, with per-wait timeouts.
// Latency: m_start 2 cycles after a push into an empty FIFO with the FSM idle; done 1 cycle after the wait ends.
// Backpressure: cmd_ready = !full; while a command is in flight further commands wait in the FIFO.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the command handshake,
// master control (m_start, m_rw/m_addr/m_data, m_busy) and status (done, timeout_err, fifo_level, idle).
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_cmd_sequencer_if.slave   bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [TMR_W-1:0]            r_timer;
    logic [TMR_W-1:0]            w_timer_nxt;
    logic [TMR_W-1:0]            w_timer_inc;
    logic                        w_tmo;
    logic                        r_err;
    logic                        w_err_nxt;
    cmd_t                        r_cmd;
    cmd_t                        w_push_cmd;
    cmd_t                        w_head;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_level;

    assign w_push_cmd = {bus.cmd_rw, bus.cmd_addr, bus.cmd_data};

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.cmd_valid),
        .i_din   (w_push_cmd),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Timer saturates at TIMEOUT_CYC so a long wait can never wrap back to a small count.
    assign w_tmo       = (r_timer == TMR_MAX);
    assign w_timer_inc = w_tmo ? r_timer : r_timer + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_err_nxt   = r_err;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_timer_nxt = '0;
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A master that answers on the very cycle the timer expires still wins.
                if (bus.m_busy) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_WAIT_DONE;
                end else if (w_tmo) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_REPORT;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.m_busy) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_REPORT;
                end else if (w_tmo) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_REPORT;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            ST_REPORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_err   <= 1'b0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_err   <= w_err_nxt;
            // Command fields only move on a pop, so they stay stable ISSUE..REPORT.
            if (w_pop) begin
                r_cmd <= w_head;
            end
        end
    end

    assign bus.cmd_ready   = !w_full;
    assign bus.fifo_level  = w_level;
    assign bus.idle        = (r_state == ST_IDLE) && w_empty;
    assign bus.m_start     = (r_state == ST_ISSUE);
    assign bus.done        = (r_state == ST_REPORT);
    assign bus.timeout_err = (r_state == ST_REPORT) && r_err;
    assign bus.m_rw        = r_cmd.rw;
    assign bus.m_addr      = r_cmd.addr;
    assign bus.m_data      = r_cmd.data;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Purpose: self-checking bench for i2c_cmd_sequencer (directed vector table, corner sequences, random vs model).
// Latency: n/a.
// Backpressure: the bench plays both host and I2C master; the master follows a per-command busy plan.
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int NEVER = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_cmd_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    i2c_cmd_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int busy_lo   = NEVER;
    int busy_hi   = -1;
    int last_done = -1;

    // One directed command: what to push, how the master answers, and the expected outcome
    // (offsets are counted in cycles from the m_start cycle).
    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         busy_dly;   // 0: master never raises busy
        int         busy_len;
        int         exp_lat;
        int         exp_off;
        logic       exp_err;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge and drive the default inputs for that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.cmd_valid = 1'b0;
        bus.m_busy    = (cyc >= busy_lo) && (cyc <= busy_hi);
    endtask

    task automatic drive_cmd(input logic [15:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = c[15];
        bus.cmd_addr  = c[14:8];
        bus.cmd_data  = c[7:0];
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        busy_lo = NEVER;
        busy_hi = -1;
        tick();
        tick();
        @(negedge clk);
        chk("rst m_start", bus.m_start, 0);
        chk("rst done", bus.done, 0);
        chk("rst timeout_err", bus.timeout_err, 0);
        chk("rst m_fields", {bus.m_rw, bus.m_addr, bus.m_data}, 0);
        chk("rst cmd_ready", bus.cmd_ready, 1);
        chk("rst fifo_level", bus.fifo_level, 0);
        chk("rst idle", bus.idle, 1);
        tick();
        rst       = 1'b0;
        last_done = -1;
    endtask

    // Call from just after a rising edge; returns at the negedge of the m_start cycle.
    task automatic wait_start(input string tag, output int s);
        s = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.m_start === 1'b1) begin
                s = cyc;
                break;
            end
            tick();
        end
        chk({tag, " m_start seen"}, (s >= 0), 1);
    endtask

    // Starts at the negedge of the m_start cycle; returns at the negedge of the done cycle.
    task automatic finish_cmd(input string tag, input int s, input logic [15:0] exp_cmd,
                              input int dly, input int len, input int exp_off,
                              input logic exp_err, input bit chk_gap);
        int d;
        chk({tag, " fields at start"}, {bus.m_rw, bus.m_addr, bus.m_data}, exp_cmd);
        if (chk_gap) chk({tag, " done-to-start gap"}, s - last_done, 2);
        if (dly == 0) begin
            busy_lo = NEVER;
            busy_hi = -1;
        end else if (dly > 0) begin
            busy_lo = s + dly;
            busy_hi = s + dly + len - 1;
        end
        d = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            @(negedge clk);
            if (bus.done === 1'b1) begin
                d = cyc;
                break;
            end
        end
        chk({tag, " done offset"}, d - s, exp_off);
        chk({tag, " timeout_err"}, bus.timeout_err, exp_err);
        chk({tag, " no m_start with done"}, bus.m_start, 0);
        chk({tag, " fields at done"}, {bus.m_rw, bus.m_addr, bus.m_data}, exp_cmd);
        busy_lo   = NEVER;
        busy_hi   = -1;
        last_done = d;
    endtask

    initial begin
        int          s;
        int          p;
        int          nc;
        int          lvl;
        int          es;
        int          ed;
        int          nf;
        int          d1;
        int          d2;
        bit          v;
        bit          ee;
        logic [15:0] cmd;
        logic [15:0] cur;
        int          exp_lvl [8] = '{0, 1, 1, 2, 3, 4, 4, 4};

        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.m_busy    = 1'b0;

        vecs[0] = '{1'b0, 7'h50, 8'hA5, 1, 6, 2, 8, 1'b0};    // plain write
        vecs[1] = '{1'b1, 7'h3C, 8'h00, 3, 9, 2, 13, 1'b0};   // busy falls on the last allowed cycle
        vecs[2] = '{1'b0, 7'h7F, 8'hFF, 2, 10, 2, 12, 1'b1};  // busy one cycle too long
        vecs[3] = '{1'b1, 7'h01, 8'h5A, 0, 0, 2, 10, 1'b1};   // busy never rises
        vecs[4] = '{1'b0, 7'h22, 8'h33, 9, 2, 2, 12, 1'b0};   // busy rises on the last allowed cycle
        vecs[5] = '{1'b1, 7'h6E, 8'h81, 10, 1, 2, 10, 1'b1};  // busy rises too late, lands in REPORT

        do_reset();

        // Directed vector table: one command at a time from an idle, empty sequencer.
        foreach (vecs[i]) begin
            tick();
            drive_cmd({vecs[i].rw, vecs[i].addr, vecs[i].data});
            p = cyc;
            wait_start($sformatf("vec%0d", i), s);
            chk($sformatf("vec%0d start latency", i), s - p, vecs[i].exp_lat);
            finish_cmd($sformatf("vec%0d", i), s, {vecs[i].rw, vecs[i].addr, vecs[i].data},
                       vecs[i].busy_dly, vecs[i].busy_len, vecs[i].exp_off, vecs[i].exp_err, 1'b0);
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d idle after", i), bus.idle, 1);
        end

        // Ordering: three queued commands issue in order, each 2 cycles after the previous done.
        tick(); drive_cmd({1'b0, 7'h10, 8'h01});
        tick(); drive_cmd({1'b1, 7'h11, 8'h02});
        tick(); drive_cmd({1'b0, 7'h12, 8'h03});
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            wait_start($sformatf("order%0d", i), s);
            finish_cmd($sformatf("order%0d", i), s, {i[0] ^ 1'b0 ? 1'b1 : 1'b0, 7'(8'h10 + i), 8'(i + 1)},
                       2, 3, 6, 1'b0, (i > 0));
        end

        // Fill with the master stuck busy: 5 commands accepted (one popped), a 6th refused while full.
        tick();
        busy_lo = 0;
        busy_hi = NEVER;
        nc = 0;
        p  = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            drive_cmd({1'b0, 7'(8'h20 + nc), 8'(8'hC0 + nc)});
            @(negedge clk);
            chk($sformatf("fill%0d level", k), bus.fifo_level, exp_lvl[k]);
            chk($sformatf("fill%0d ready", k), bus.cmd_ready, (exp_lvl[k] < DEPTH));
            chk($sformatf("fill%0d m_start", k), bus.m_start, (k == 2));
            if (bus.m_start === 1'b1) p = cyc;
            if (bus.cmd_ready === 1'b1 && nc < 5) nc++;
        end
        // Stuck busy in WAIT_DONE: aborted 11 cycles after m_start, then the queue drains in order.
        finish_cmd("stuck", p, {1'b0, 7'h20, 8'hC0}, -1, 0, 11, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) begin
            tick();
            wait_start($sformatf("drain%0d", i), s);
            finish_cmd($sformatf("drain%0d", i), s, {1'b0, 7'(8'h20 + i), 8'(8'hC0 + i)},
                       0, 0, 10, 1'b1, 1'b1);
        end
        tick();
        @(negedge clk);
        chk("drain idle", bus.idle, 1);
        chk("drain level", bus.fifo_level, 0);

        // Reset mid-command with two commands still queued.
        busy_lo = 0;
        busy_hi = NEVER;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_cmd({1'b1, 7'(8'h40 + i), 8'h77});
        end
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        chk("midrst level before", bus.fifo_level, 2);
        do_reset();
        for (int i = 0; i < 15; i++) begin
            tick();
            @(negedge clk);
            chk("midrst done", bus.done, 0);
            chk("midrst m_start", bus.m_start, 0);
            chk("midrst level", bus.fifo_level, 0);
            chk("midrst idle", bus.idle, 1);
        end

        // Random traffic against a cycle-accurate transaction model.
        do_reset();
        q.delete();
        nf  = cyc;
        es  = -1;
        ed  = -1;
        ee  = 1'b0;
        cur = '0;
        for (int n = 0; n < 1500; n++) begin
            v   = ($urandom_range(0, 2) == 0);
            cmd = 16'($urandom);
            if (v) drive_cmd(cmd);
            @(negedge clk);
            lvl = q.size();
            chk("rnd level", bus.fifo_level, lvl);
            chk("rnd ready", bus.cmd_ready, (lvl < DEPTH));
            chk("rnd m_start", bus.m_start, (cyc == es));
            chk("rnd done", bus.done, (cyc == ed));
            if (cyc == ed) chk("rnd timeout_err", bus.timeout_err, ee);
            chk("rnd idle", bus.idle, (cyc >= nf) && (lvl == 0));
            chk("rnd fields", {bus.m_rw, bus.m_addr, bus.m_data}, cur);
            if (cyc >= nf && lvl > 0) begin
                cur = q.pop_front();
                es  = cyc + 1;
                if ($urandom_range(0, 4) == 0) begin
                    busy_lo = NEVER;
                    busy_hi = -1;
                    ed      = es + TMO + 2;
                    ee      = 1'b1;
                end else begin
                    d1      = $urandom_range(1, TMO + 1);
                    d2      = $urandom_range(1, TMO + 4);
                    busy_lo = es + d1;
                    busy_hi = es + d1 + d2 - 1;
                    if (d2 > TMO + 1) begin
                        ed = es + d1 + TMO + 2;
                        ee = 1'b1;
                    end else begin
                        ed = es + d1 + d2 + 1;
                        ee = 1'b0;
                    end
                end
                nf = ed + 1;
            end
            if (v && lvl < DEPTH) q.push_back(cmd);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
